// File: rtl/arm_mc_decoder.sv
// Multicycle ARM control FSM driving datapath selects and pre-condition write requests.
// Optional ARM_MC_ILLEGAL_TRAP_EN: undefined opcode (Op=11) traps into an absorbing HALT state.
module arm_mc_decoder #(
  parameter int MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       PCS,
  output logic [1:0] FlagW,
  output logic       halted
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    HALT     = 4'd10
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state, state_n;
  logic [3:0] wait_cnt;
  logic [1:0] alu_dec;
  logic       pc_dst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_n;
      // Counter reads 0 on the first MEMRD cycle and counts extra wait cycles.
      wait_cnt <= (state == MEMRD) ? wait_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    case (Funct[4:1])
      4'b0100: alu_dec = 2'b00;
      4'b0010: alu_dec = 2'b01;
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      default: alu_dec = 2'b00;
    endcase
  end

  assign pc_dst = (Rd == 4'hF);

  always_comb begin
    state_n = state;
    case (state)
      FETCH:  state_n = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_n = MEMADR;
          2'b00:   state_n = Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_n = BRANCH;
`ifdef ARM_MC_ILLEGAL_TRAP_EN
          default: state_n = HALT;
`else
          default: state_n = FETCH;
`endif
        endcase
      end
      MEMADR:   state_n = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_n = (wait_cnt == LAT) ? MEMWB : MEMRD;
      MEMWB:    state_n = FETCH;
      MEMWR:    state_n = FETCH;
      EXECUTER: state_n = ALUWB;
      EXECUTEI: state_n = ALUWB;
      ALUWB:    state_n = FETCH;
      BRANCH:   state_n = FETCH;
`ifdef ARM_MC_ILLEGAL_TRAP_EN
      HALT:     state_n = HALT;
`endif
      default:  state_n = FETCH;
    endcase
  end

  always_comb begin
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    NextPC     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    PCS        = 1'b0;
    FlagW      = 2'b00;
    case (state)
      FETCH: begin
        // Reset parks the FSM here; hold the enables off until it releases.
        IRWrite   = ~reset;
        NextPC    = ~reset;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMRD:    AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        PCS       = pc_dst;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB    = (state == EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = alu_dec;
        FlagW[1]   = Funct[0];
        FlagW[0]   = Funct[0] & ~alu_dec[1];
      end
      ALUWB: begin
        RegW = 1'b1;
        PCS  = pc_dst;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCS       = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ARM_MC_ILLEGAL_TRAP_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_arm_mc_decoder.sv
// Directed bench for arm_mc_decoder (MEM_LAT=2); checks per-cycle output vectors.
module tb_arm_mc_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, PCS, halted;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
  logic [14:0] outs;

  int checks = 0;
  int errors = 0;

  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,NextPC,RegW,MemW,PCS,FlagW}
  localparam logic [14:0] V_FETCH  = 15'b1_0_1_10_10_00_1_0_0_0_00;
  localparam logic [14:0] V_DECODE = 15'b0_0_1_10_10_00_0_0_0_0_00;
  localparam logic [14:0] V_RESET  = 15'b0_0_1_10_10_00_0_0_0_0_00;
  localparam logic [14:0] V_MEMADR = 15'b0_0_0_01_00_00_0_0_0_0_00;
  localparam logic [14:0] V_MEMRD  = 15'b0_1_0_00_00_00_0_0_0_0_00;
  localparam logic [14:0] V_MEMWB  = 15'b0_0_0_00_01_00_0_1_0_0_00;
  localparam logic [14:0] V_MEMWR  = 15'b0_1_0_00_00_00_0_0_1_0_00;
  localparam logic [14:0] V_EXR_AS = 15'b0_0_0_00_00_00_0_0_0_0_11;
  localparam logic [14:0] V_EXI_SB = 15'b0_0_0_01_00_01_0_0_0_0_00;
  localparam logic [14:0] V_ALUWB  = 15'b0_0_0_00_00_00_0_1_0_0_00;
  localparam logic [14:0] V_ALUWBP = 15'b0_0_0_00_00_00_0_1_0_1_00;
  localparam logic [14:0] V_BRANCH = 15'b0_0_0_01_10_00_0_0_0_1_00;
  localparam logic [14:0] V_HALT   = 15'b0_0_0_00_00_00_0_0_0_0_00;

  assign outs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
                 NextPC, RegW, MemW, PCS, FlagW};

  arm_mc_decoder #(.MEM_LAT(2)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .NextPC(NextPC),
    .RegW(RegW), .MemW(MemW), .PCS(PCS), .FlagW(FlagW), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Op = 2'b00; Funct = 6'b0; Rd = 4'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (outs !== V_RESET || halted !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got outs=%b halted=%b want outs=%b halted=0", i, outs, halted, V_RESET);
      end
      cyc();
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== V_FETCH) begin
      errors++;
      $display("FAIL reset_release_fetch: got %b want %b", outs, V_FETCH);
    end
    cyc();
    checks++;
    if (outs !== V_DECODE) begin
      errors++;
      $display("FAIL reset_then_decode: got %b want %b", outs, V_DECODE);
    end
    // Let the NOP decode of Op=00/Funct=0 finish: EXECUTER (AND, no S) then ALUWB.
    cyc();
    checks++;
    if (outs !== 15'b0_0_0_00_00_10_0_0_0_0_00) begin
      errors++;
      $display("FAIL reset_and_exec: got %b want %b", outs, 15'b0_0_0_00_00_10_0_0_0_0_00);
    end
    cyc();
    cyc();
  endtask

  task automatic test_add_reg();
    logic [14:0] exp [5];
    exp = '{V_FETCH, V_DECODE, V_EXR_AS, V_ALUWB, V_FETCH};
    Op = 2'b00; Funct = 6'b001001; Rd = 4'd3;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL add_reg[%0d]: got %b want %b", i, outs, exp[i]);
      end
      if (i < 4) cyc();
    end
  endtask

  task automatic test_sub_imm_pc();
    logic [14:0] exp [5];
    exp = '{V_FETCH, V_DECODE, V_EXI_SB, V_ALUWBP, V_FETCH};
    Op = 2'b00; Funct = 6'b100100; Rd = 4'hF;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL sub_imm_pc[%0d]: got %b want %b", i, outs, exp[i]);
      end
      if (i < 4) cyc();
    end
  endtask

  task automatic test_ldr();
    logic [14:0] exp [8];
    exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB, V_FETCH};
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd2;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL ldr_lat2[%0d]: got %b want %b", i, outs, exp[i]);
      end
      if (i < 7) cyc();
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp [8];
    exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_FETCH, V_DECODE, V_BRANCH, V_FETCH};
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd5;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        Op = 2'b10; Funct = 6'b100000; Rd = 4'd0;
      end
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL str_branch[%0d]: got %b want %b", i, outs, exp[i]);
      end
      if (i < 7) cyc();
    end
  endtask

  task automatic test_undef();
    Op = 2'b11; Funct = 6'b111111; Rd = 4'hF;
    checks++;
    if (outs !== V_FETCH) begin
      errors++;
      $display("FAIL undef_fetch: got %b want %b", outs, V_FETCH);
    end
    cyc();
    checks++;
    if (outs !== V_DECODE) begin
      errors++;
      $display("FAIL undef_decode: got %b want %b", outs, V_DECODE);
    end
    cyc();
`ifdef ARM_MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (outs !== V_HALT || halted !== 1'b1) begin
        errors++;
        $display("FAIL undef_halt[%0d]: got outs=%b halted=%b want outs=%b halted=1", i, outs, halted, V_HALT);
      end
      cyc();
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0 || outs !== V_RESET) begin
      errors++;
      $display("FAIL halt_async_clear: got outs=%b halted=%b want outs=%b halted=0", outs, halted, V_RESET);
    end
    cyc();
    @(negedge clk);
    reset = 1'b0;
    #1;
`else
    checks++;
    if (outs !== V_FETCH || halted !== 1'b0) begin
      errors++;
      $display("FAIL undef_nop_return: got outs=%b halted=%b want outs=%b halted=0", outs, halted, V_FETCH);
    end
`endif
  endtask

  task automatic test_reset_abort();
    Op = 2'b00; Funct = 6'b001001; Rd = 4'd3;
    cyc();
    cyc();
    cyc();
    checks++;
    if (outs !== V_ALUWB) begin
      errors++;
      $display("FAIL abort_pre_aluwb: got %b want %b", outs, V_ALUWB);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outs !== V_RESET) begin
      errors++;
      $display("FAIL abort_async: got %b want %b", outs, V_RESET);
    end
    cyc();
    cyc();
    checks++;
    if (outs !== V_RESET) begin
      errors++;
      $display("FAIL abort_hold: got %b want %b", outs, V_RESET);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== V_FETCH) begin
      errors++;
      $display("FAIL abort_refetch: got %b want %b", outs, V_FETCH);
    end
    cyc();
    checks++;
    if (outs !== V_DECODE) begin
      errors++;
      $display("FAIL abort_redecode: got %b want %b", outs, V_DECODE);
    end
  endtask

  initial begin
    test_reset();
    test_add_reg();
    test_sub_imm_pc();
    test_ldr();
    test_back_to_back();
    test_undef();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
